// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch front end with 2-entry prefetch buffer and halt detection
module instr_fetch #(
   parameter int w       = 8,
   parameter int op_w    = 3,
   parameter int addr_w  = 8,
   parameter int instr_w = 11
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [addr_w-1:0]  start_addr,
   output logic               mem_req,
   output logic [addr_w-1:0]  mem_addr,
   input  logic [instr_w-1:0] mem_rdata,
   input  logic               mem_valid,
   output logic [op_w-1:0]    op,
   output logic [w-1:0]       operand,
   output logic               issue_valid,
   input  logic               issue_ready,
   output logic [addr_w-1:0]  pc,
   output logic               halted
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [instr_w-1:0] buf_q [2];
   logic               head_q;
   logic [1:0]         count_q;
   logic               outstanding_q;
   logic [addr_w-1:0]  pc_q;
   logic [addr_w-1:0]  mem_addr_q;

   logic               complete;
   logic               pop;
   logic               req_raise;
   logic               halt_in;
   logic               halt_out;
   logic               tail;

   // handshake decode: completion, issue transfer, request launch, halt detection
   always_comb begin
      complete  = outstanding_q & mem_valid;
      pop       = issue_valid & issue_ready;
      // only one request may be in flight, so the slot check reduces to count < 2
      req_raise = (state == RUN) & ~outstanding_q & (count_q < 2'd2);
      halt_in   = (mem_rdata[instr_w-1:w] == '0);
      halt_out  = pop & (op == '0);
      tail      = head_q ^ count_q[0];
   end

   // next-state logic; start is only honoured from IDLE, HALTED is left only by reset
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (complete && halt_in) state_next = DRAIN;
         DRAIN:   if (halt_out) state_next = HALTED;
         HALTED:  state_next = HALTED;
         default: state_next = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // program counter and the single outstanding memory request
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q          <= '0;
         mem_addr_q    <= '0;
         outstanding_q <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            pc_q <= start_addr;
         end else if (complete) begin
            pc_q <= pc_q + addr_w'(1);
         end
         if (req_raise) begin
            outstanding_q <= 1'b1;
            mem_addr_q    <= pc_q;
         end else if (complete) begin
            outstanding_q <= 1'b0;
         end
      end
   end

   // two-entry circular prefetch buffer; a push with count=1 and a pop lands the new word at the head
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            buf_q[i] <= '0;
         end
         head_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (complete) begin
            buf_q[tail] <= mem_rdata;
         end
         if (pop) begin
            head_q <= ~head_q;
         end
         case ({complete, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign mem_req     = outstanding_q;
   assign mem_addr    = mem_addr_q;
   assign pc          = pc_q;
   assign issue_valid = (count_q != 2'd0) && (state != HALTED);
   assign op          = buf_q[head_q][instr_w-1:w];
   assign operand     = buf_q[head_q][w-1:0];
   assign halted      = (state == HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  start_addr = 8'h00;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic [10:0] mem_rdata;
   logic        mem_valid;
   logic [2:0]  op;
   logic [7:0]  operand;
   logic        issue_valid;
   logic        issue_ready = 1'b0;
   logic [7:0]  pc;
   logic        halted;

   logic        resp_en = 1'b0;
   logic        t_valid = 1'b0;
   logic [10:0] t_rdata = 11'h0;
   logic        r_valid = 1'b0;
   logic [10:0] r_rdata = 11'h0;

   assign mem_valid = resp_en ? r_valid : t_valid;
   assign mem_rdata = resp_en ? r_rdata : t_rdata;

   instr_fetch dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .start_addr  (start_addr),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .mem_valid   (mem_valid),
      .op          (op),
      .operand     (operand),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .pc          (pc),
      .halted      (halted)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // program memory and responder with configurable latency
   logic [10:0] mem [256];
   int  fixed_lat = 1;
   bit  lat_rand = 1'b0;
   int  wcnt = 0;
   int  cur_lat = 1;

   always @(posedge clock) begin
      #1;
      if (mem_req) begin
         if (wcnt == 0) cur_lat = lat_rand ? int'($urandom_range(1, 4)) : fixed_lat;
         wcnt++;
         if (wcnt >= cur_lat) begin
            r_valid = 1'b1;
            r_rdata = mem[mem_addr];
            wcnt    = 0;
         end else begin
            r_valid = 1'b0;
         end
      end else begin
         r_valid = 1'b0;
         wcnt    = 0;
      end
   end

   // monitor: completed requests, issued words, request stability during waits
   logic [7:0]  req_log [$];
   logic [10:0] iss_log [$];
   int          stab_err = 0;
   logic        prev_wait = 1'b0;
   logic [7:0]  prev_addr = 8'h00;

   always @(negedge clock) begin
      if (!reset) begin
         if (mem_req && mem_valid) req_log.push_back(mem_addr);
         if (issue_valid && issue_ready) iss_log.push_back({op, operand});
         if (prev_wait && (!mem_req || mem_addr != prev_addr)) stab_err++;
         prev_wait = mem_req && !mem_valid;
         prev_addr = mem_addr;
      end else begin
         prev_wait = 1'b0;
      end
   end

   // reference model: program from start address through the first halt word
   logic [7:0]  exp_a [$];
   logic [10:0] exp_w [$];
   int r0, i0, s0;

   task automatic load_prog(input logic [7:0] sa, input int n, input logic [2:0] fixed_op);
      logic [2:0] o;
      logic [7:0] d;
      exp_a.delete();
      exp_w.delete();
      for (int i = 0; i <= n; i++) begin
         o = (i == n) ? 3'd0 : ((fixed_op != 3'd0) ? fixed_op : 3'($urandom_range(1, 7)));
         d = 8'($urandom);
         mem[8'(sa + i)] = {o, d};
         exp_a.push_back(8'(sa + i));
         exp_w.push_back({o, d});
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; issue_ready = 1'b0; t_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic begin_prog(input logic [7:0] sa);
      r0 = req_log.size(); i0 = iss_log.size(); s0 = stab_err;
      start = 1'b1; start_addr = sa;
      step();
      start = 1'b0;
   endtask

   task automatic finish_prog(input string tag, input logic [7:0] sa, input int rdy_pct, input bit start_mid);
      int cyc;
      cyc = 0;
      while (!halted && cyc < 3000) begin
         issue_ready = ($urandom_range(0, 99) < rdy_pct);
         if (start_mid && cyc == 5) begin
            start = 1'b1; start_addr = sa ^ 8'h80;
         end else begin
            start = 1'b0;
         end
         step();
         cyc++;
      end
      issue_ready = 1'b1;
      start = 1'b1; start_addr = sa ^ 8'h40;
      step();
      start = 1'b0;
      step();
      step();
      chk({tag, "_halted"}, halted, 1);
      chk({tag, "_pc"}, pc, 8'(exp_a[exp_a.size()-1] + 1));
      chk({tag, "_req_idle"}, mem_req, 0);
      chk({tag, "_iv_idle"}, issue_valid, 0);
      chk({tag, "_nreq"}, req_log.size() - r0, exp_a.size());
      for (int k = 0; k < exp_a.size() && r0 + k < req_log.size(); k++)
         chk($sformatf("%s_req%0d", tag, k), req_log[r0+k], exp_a[k]);
      chk({tag, "_niss"}, iss_log.size() - i0, exp_w.size());
      for (int k = 0; k < exp_w.size() && i0 + k < iss_log.size(); k++)
         chk($sformatf("%s_iss%0d", tag, k), iss_log[i0+k], exp_w[k]);
      chk({tag, "_stable"}, stab_err - s0, 0);
   endtask

   typedef struct {
      logic        st;
      logic [7:0]  sa;
      logic        mv;
      logic [10:0] rd;
      logic        rdy;
      logic        e_req;
      logic [7:0]  e_addr;
      logic        e_iv;
      logic [2:0]  e_op;
      logic [7:0]  e_opr;
      logic [7:0]  e_pc;
      logic        e_h;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [7:0] sa;
      int n;

      // basic stream at latency 1, then start pulses in HALTED
      tbl[0]  = '{1'b1, 8'h10, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h10, 1'b0};
      tbl[2]  = '{1'b0, 8'h00, 1'b1, 11'h1AB, 1'b1, 1'b1, 8'h10, 1'b0, 3'd0, 8'h00, 8'h10, 1'b0};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 8'hAB, 8'h11, 1'b0};
      tbl[4]  = '{1'b0, 8'h00, 1'b1, 11'h2CD, 1'b1, 1'b1, 8'h11, 1'b0, 3'd0, 8'h00, 8'h11, 1'b0};
      tbl[5]  = '{1'b0, 8'h00, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b1, 3'd2, 8'hCD, 8'h12, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 11'h0FF, 1'b1, 1'b1, 8'h12, 1'b0, 3'd0, 8'h00, 8'h12, 1'b0};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 8'hFF, 8'h13, 1'b0};
      tbl[8]  = '{1'b1, 8'h55, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h13, 1'b1};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h13, 1'b1};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 11'h000, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h13, 1'b1};

      resp_en = 1'b0;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("tbl%0d_req", i), mem_req, tbl[i].e_req);
         if (i == 0 || tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
         chk($sformatf("tbl%0d_iv", i), issue_valid, tbl[i].e_iv);
         if (i == 0 || tbl[i].e_iv) begin
            chk($sformatf("tbl%0d_op", i), op, tbl[i].e_op);
            chk($sformatf("tbl%0d_opr", i), operand, tbl[i].e_opr);
         end
         chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
         chk($sformatf("tbl%0d_halted", i), halted, tbl[i].e_h);
         start = tbl[i].st; start_addr = tbl[i].sa;
         t_valid = tbl[i].mv; t_rdata = tbl[i].rd; issue_ready = tbl[i].rdy;
         step();
      end
      start = 1'b0; t_valid = 1'b0;

      // backpressure: buffer fills to two and requests stop
      resp_en = 1'b1; lat_rand = 1'b0; fixed_lat = 1;
      do_reset();
      load_prog(8'h40, 5, 3'd5);
      begin_prog(8'h40);
      repeat (10) step();
      chk("bp_fetched", req_log.size() - r0, 2);
      chk("bp_req", mem_req, 0);
      chk("bp_iv", issue_valid, 1);
      chk("bp_op", op, 5);
      finish_prog("bp", 8'h40, 100, 1'b0);

      // long memory latency with random backpressure
      fixed_lat = 5;
      do_reset();
      load_prog(8'h80, 4, 3'd0);
      begin_prog(8'h80);
      finish_prog("lat", 8'h80, 70, 1'b0);

      // address wrap through 0xFF
      fixed_lat = 1;
      do_reset();
      load_prog(8'hFE, 2, 3'd0);
      begin_prog(8'hFE);
      finish_prog("wrap", 8'hFE, 100, 1'b0);

      // reset with one buffered word and a request outstanding
      resp_en = 1'b0;
      do_reset();
      load_prog(8'h20, 3, 3'd0);
      start = 1'b1; start_addr = 8'h20;
      step();
      start = 1'b0;
      step();
      chk("rst_pre_req", mem_req, 1);
      chk("rst_pre_addr", mem_addr, 8'h20);
      t_valid = 1'b1; t_rdata = mem[8'h20];
      step();
      t_valid = 1'b0;
      step();
      chk("rst_pre_iv", issue_valid, 1);
      chk("rst_pre_req2", mem_req, 1);
      reset = 1'b1;
      step();
      reset = 1'b0; t_valid = 1'b1; t_rdata = mem[8'h21];
      chk("rst_iv", issue_valid, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_pc", pc, 0);
      chk("rst_halted", halted, 0);
      step();
      t_valid = 1'b0;
      chk("rst_late_iv", issue_valid, 0);
      chk("rst_late_pc", pc, 0);
      chk("rst_late_req", mem_req, 0);
      step();
      chk("rst_idle_req", mem_req, 0);
      resp_en = 1'b1;
      load_prog(8'h30, 3, 3'd0);
      begin_prog(8'h30);
      finish_prog("rst_after", 8'h30, 100, 1'b0);

      // start pulse while running
      do_reset();
      load_prog(8'h60, 6, 3'd0);
      begin_prog(8'h60);
      finish_prog("start_run", 8'h60, 100, 1'b1);

      // randomized programs, latencies and backpressure
      lat_rand = 1'b1;
      for (int it = 0; it < 25; it++) begin
         do_reset();
         sa = 8'($urandom);
         n  = $urandom_range(0, 7);
         load_prog(sa, n, 3'd0);
         begin_prog(sa);
         finish_prog($sformatf("rnd%0d", it), sa, $urandom_range(20, 100), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front end of the CPU: fetches instruction words from program memory and splits each word into an opcode and an operand field.
- Presents opcodes to the decoder through a valid/ready issue handshake.
- Keeps a 2-entry prefetch buffer so memory latency is hidden from the decoder.
- Stops fetching after fetching a halt (opcode 0) and reports halted once that halt has been issued.

Parameters:
- w, 8, data width of the operand field.
- op_w, 3, opcode width; must match the decoder.
- addr_w, 8, program address width.
- instr_w, 11, instruction word width. Must equal op_w + w; opcode is bits [instr_w-1:w], operand is bits [w-1:0].

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; starts fetching at start_addr (honoured only in IDLE).
- start_addr  input  addr_w  first program address.
- mem_req  output  1  read request to program memory.
- mem_addr  output  addr_w  read address; stable while mem_req=1.
- mem_rdata  input  instr_w  read data.
- mem_valid  input  1  mem_rdata valid; completes the outstanding request.
- op  output  op_w  opcode of the buffer head.
- operand  output  w  operand of the buffer head.
- issue_valid  output  1  buffer head is valid.
- issue_ready  input  1  consumer accepts the head.
- pc  output  addr_w  address of the next word to request.
- halted  output  1  halt has been issued; fetching stopped.

Behaviour:
- Reset, applied on a rising edge with reset=1:
  - Outputs: mem_req=0, mem_addr=0, issue_valid=0, op=0, operand=0, pc=0, halted=0.
  - Internal: buffer count=0, outstanding=0, state=IDLE.
  - Reset mid-operation: buffer is flushed and any outstanding request is abandoned. A mem_valid arriving while outstanding=0 is ignored.
- State machine, states IDLE, RUN, DRAIN, HALTED:
  - IDLE: start=1 -> pc<=start_addr, go RUN. Start is ignored in every other state.
  - RUN: fetch and issue as described below. A returned word with opcode 0 is pushed into the buffer, stops all further requests, and moves the FSM to DRAIN. pc still increments past the halt word.
  - DRAIN: no new requests. Buffer entries continue to issue. When the halt entry issues (issue_valid & issue_ready with op=0), go HALTED.
  - HALTED: halted=1, mem_req=0, issue_valid=0. Only reset leaves HALTED.
- Memory handshake:
  - At most one outstanding request at a time.
  - A request is raised only in RUN, with outstanding=0 and (count + outstanding) < 2. This means buffer overflow is impossible.
  - mem_req rises on the edge after the condition holds, with mem_addr=pc.
  - mem_req and mem_addr are held until the cycle mem_valid=1 is sampled.
  - On that edge: the word is pushed, pc<=pc+1 (wraps modulo 2^addr_w), outstanding<=0, and mem_req drops.
  - mem_valid may arrive in the same cycle mem_req first appears. Minimum latency is 1 cycle; there is no maximum.
  - The next request may be raised on the edge following completion.
- Issue handshake:
  - issue_valid=1 whenever count>0.
  - op and operand are driven from the head entry and are stable until accepted.
  - Transfer occurs on a rising edge when issue_valid & issue_ready; the head pops.
  - Push and pop in the same cycle: count unchanged and order preserved. With count=1, the pushed word becomes the head next cycle.
  - Push to an empty buffer: issue_valid=1 on the following cycle, i.e. 1 cycle after the mem_valid edge.
- Throughput: at single-cycle memory latency with issue_ready held high, one instruction issues every 2 cycles (request, response).
- Opcodes 1..7 pass through unmodified; the block only interprets opcode 0.

Test Plan:
- Basic stream:
  - Stimulus: reset, start with start_addr=0x10; memory latency 1 holds 0x1AB, 0x2CD, 0x0FF at 0x10..0x12; issue_ready=1.
  - Required: issues op/operand 1/0xAB, 2/0xCD, 0/0xFF in order; halted=1 the cycle after the halt issues; pc=0x13; no request to 0x13.
- Backpressure:
  - Stimulus: issue_ready=0 for 10 cycles, latency 1, program of five opcode-5 words.
  - Required: exactly 2 words buffered and mem_req stays 0; when ready rises, the remaining words issue in order with none lost or duplicated.
- Variable latency:
  - Stimulus: mem_valid delayed 4 cycles per request.
  - Required: mem_addr stable and mem_req high throughout each wait; each address is requested exactly once.
- Address wrap:
  - Stimulus: start_addr=0xFE; words at 0xFE, 0xFF, 0x00, with 0x00 holding a halt.
  - Required: request sequence 0xFE, 0xFF, 0x00; final pc=0x01.
- Reset mid-operation:
  - Stimulus: assert reset while a request is outstanding and the buffer holds 1 entry; mem_valid arrives 1 cycle after reset.
  - Required: issue_valid=0, mem_req=0, pc=0, FSM in IDLE; the late mem_valid is ignored; a subsequent start fetches normally.
- Start ignored:
  - Stimulus: start pulses while in RUN and while in HALTED.
  - Required: pc and fetch stream unaffected; halted stays 1 in HALTED.
